bit_serializer: RTL

Parallel-to-serial front end for the 101 sequence-detector stage. Accepts WIDTH-bit words over a valid/ready handshake. Shifts them out one bit per clock on a single-bit stream that the detector's `in` port samples every cycle. A one-word holding register lets back-to-back words stream with no idle gap between them.

---
 rtl/serializer_pkg.sv | 9 +
 rtl/word_hold_reg.sv | 26 ++
 rtl/bit_serializer.sv | 105 ++++++++++
 3 files changed

// File: rtl/serializer_pkg.sv
// Shared types for the bit serializer front end.
package serializer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } ser_state_t;

endpackage

// File: rtl/word_hold_reg.sv
// One-word holding register with a full flag. A write fills it, and a take empties it.
module word_hold_reg #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             take,
  output logic [WIDTH-1:0] data,
  output logic             full
);

  always_ff @(posedge clk) begin
    if (!rst) begin
      data <= '0;
      full <= 1'b0;
    end else if (wr_en) begin
      data <= wr_data;
      full <= 1'b1;
    end else if (take) begin
      full <= 1'b0;
    end
  end

endmodule

// File: rtl/bit_serializer.sv
// Parallel-to-serial front end: WIDTH-bit words in over valid/ready, one bit per clock out.
module bit_serializer
  import serializer_pkg::*;
#(
  parameter int unsigned WIDTH     = 8,
  parameter bit          MSB_FIRST = 1'b1,
  parameter bit          IDLE_BIT  = 1'b0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             load_valid,
  output logic             load_ready,
  output logic             serial_out,
  output logic             serial_valid,
  output logic             frame_done
);

  localparam int unsigned CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  ser_state_t       state, state_nxt;
  logic [WIDTH-1:0] sreg, sreg_nxt, sreg_shifted;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic [WIDTH-1:0] hold_data;
  logic             hold_full, hold_wr, hold_take;
  logic             accept, last_bit, cur_bit;

  word_hold_reg #(.WIDTH(WIDTH)) u_hold (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (hold_wr),
    .wr_data (data_in),
    .take    (hold_take),
    .data    (hold_data),
    .full    (hold_full)
  );

  // The shift direction follows the bit order so that the outgoing bit always sits at the same end.
  always_comb begin
    if (MSB_FIRST) begin
      sreg_shifted = {sreg[WIDTH-2:0], 1'b0};
      cur_bit      = sreg[WIDTH-1];
    end else begin
      sreg_shifted = {1'b0, sreg[WIDTH-1:1]};
      cur_bit      = sreg[0];
    end
  end

  assign load_ready   = rst && !hold_full;
  assign accept       = load_valid && load_ready;
  assign last_bit     = (state == SHIFT) && (cnt == CNT_LAST);
  assign serial_out   = (state == SHIFT) ? cur_bit : IDLE_BIT;
  assign serial_valid = (state == SHIFT);
  assign frame_done   = last_bit;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      sreg  <= '0;
      cnt   <= '0;
    end else begin
      state <= state_nxt;
      sreg  <= sreg_nxt;
      cnt   <= cnt_nxt;
    end
  end

  // Next-state logic. On the last bit, a held word takes priority over a new word that bypasses the holding register.
  always_comb begin
    state_nxt = state;
    sreg_nxt  = sreg;
    cnt_nxt   = cnt;
    hold_wr   = 1'b0;
    hold_take = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          sreg_nxt  = data_in;
          cnt_nxt   = '0;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        if (!last_bit) begin
          sreg_nxt = sreg_shifted;
          cnt_nxt  = cnt + CNT_W'(1);
          hold_wr  = accept;
        end else if (hold_full) begin
          sreg_nxt  = hold_data;
          hold_take = 1'b1;
          cnt_nxt   = '0;
        end else if (accept) begin
          sreg_nxt = data_in;
          cnt_nxt  = '0;
        end else begin
          cnt_nxt   = '0;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
